// File: rtl/ovl_req_ack_responder.sv
// ovl_req_ack_responder: queued req->ack responder with programmable latency; ports clock/reset, enable/req_in/delay/inject_err in; ack/busy/pending/overflow/ack_count/err_count out
module ovl_req_ack_responder #(
  parameter int DW    = 4,
  parameter int DEPTH = 4,
  parameter int CW    = 16,
  localparam int PW   = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          req_in,
  input  logic [DW-1:0] delay,
  input  logic          inject_err,
  output logic          ack,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow,
  output logic [CW-1:0] ack_count,
  output logic [CW-1:0] err_count
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t        state;
  logic [DW-1:0] cnt;
  logic          acc;
  logic [DW-1:0] deff_m1;
  logic [PW:0]   q;
  assign acc     = enable & req_in;
  assign deff_m1 = (delay == '0) ? '0 : delay - DW'(1);
  // queue depth after this edge's arrival, one bit wider so DEPTH+1 cannot wrap
  assign q       = {1'b0, pending} + (PW+1)'(acc);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      pending   <= '0;
      overflow  <= 1'b0;
      ack_count <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          cnt   <= deff_m1;
          state <= WAIT;
          busy  <= 1'b1;
        end
        WAIT: begin
          if (acc) begin
            if (pending < PW'(DEPTH)) pending <= pending + PW'(1);
            else overflow <= 1'b1;
          end
          if (cnt != '0) cnt <= cnt - DW'(1);
          else begin
            state <= ACK;
            ack   <= ~inject_err;
            if (inject_err) err_count <= err_count + CW'(1);
            else ack_count <= ack_count + CW'(1);
          end
        end
        ACK: begin
          ack <= 1'b0;
          // a request arriving now counts toward the queue, so it can start back-to-back
          if (q != '0) begin
            pending <= PW'(q - (PW+1)'(1));
            cnt     <= deff_m1;
            state   <= WAIT;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_ovl_req_ack_responder.sv
// tb_ovl_req_ack_responder: randomized + directed check of ovl_req_ack_responder against a timeline model
module tb_ovl_req_ack_responder;
  localparam int DEPTH = 4;
  logic        clock = 0, reset = 1, enable = 0, req_in = 0, inject_err = 0;
  logic [3:0]  delay = 0;
  logic        ack, busy, overflow;
  logic [2:0]  pending;
  logic [15:0] ack_count, err_count;
  int errs = 0, checks = 0;
  int t = 0, m_ack_edge = -10, m_pend = 0;
  bit m_ovf = 0, m_ackv = 0;
  logic [15:0] m_ack = 0, m_err = 0;

  ovl_req_ack_responder dut (
    .clock(clock), .reset(reset), .enable(enable), .req_in(req_in), .delay(delay),
    .inject_err(inject_err), .ack(ack), .busy(busy), .pending(pending),
    .overflow(overflow), .ack_count(ack_count), .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s t=%0d got=%0d expected=%0d", tag, t, got, exp);
    end
  endtask

  function automatic int deff(input logic [3:0] d);
    return (d == 0) ? 1 : int'(d);
  endfunction

  task automatic model_clear();
    m_ack_edge = -10; m_pend = 0; m_ovf = 0; m_ackv = 0; m_ack = 0; m_err = 0;
  endtask

  task automatic check_all();
    chk("ack", ack, m_ackv);
    chk("busy", busy, t <= m_ack_edge);
    chk("pending", pending, m_pend);
    chk("overflow", overflow, m_ovf);
    chk("ack_count", ack_count, m_ack);
    chk("err_count", err_count, m_err);
  endtask

  // Model works on the timeline: each serviced request owns an ack edge; the
  // next one can start on the edge right after that ack.
  task automatic cycle(input bit r, input bit e, input logic [3:0] d, input bit inj);
    bit acc;
    req_in = r; enable = e; delay = d; inject_err = inj;
    @(posedge clock);
    t++;
    acc = r & e;
    m_ackv = 0;
    if (t > m_ack_edge + 1) begin
      if (acc) m_ack_edge = t + deff(d);
    end else if (t == m_ack_edge + 1) begin
      if (m_pend + int'(acc) > 0) begin
        m_pend = m_pend + int'(acc) - 1;
        m_ack_edge = t + deff(d);
      end
    end else begin
      if (acc) begin
        if (m_pend < DEPTH) m_pend++;
        else m_ovf = 1;
      end
      if (t == m_ack_edge) begin
        m_ackv = !inj;
        if (inj) m_err++;
        else m_ack++;
      end
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2 reset = 1;
    #1;
    model_clear();
    m_ack_edge = t - 10;
    check_all();
    @(negedge clock) reset = 0;
  endtask

  task automatic idle(input int n, input logic [3:0] d);
    for (int i = 0; i < n; i++) cycle(0, 1, d, 0);
  endtask

  initial begin
    #12;
    check_all();
    @(negedge clock) reset = 0;
    idle(4, 3);
    cycle(1, 1, 3, 0);
    idle(8, 3);
    chk("plan_ack_count", ack_count, 1);
    cycle(1, 1, 0, 0);
    idle(5, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 2, 0);
    idle(10, 2);
    chk("b2b_overflow", overflow, 0);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, 1, 15, 0);
    chk("ovf_pending", pending, 4);
    idle(100, 15);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_acks", ack_count, 5);
    do_reset();
    cycle(1, 1, 4, 0);
    idle(3, 4);
    cycle(0, 1, 4, 1);
    chk("err_ack_low", ack, 0);
    idle(4, 4);
    chk("err_count", err_count, 1);
    for (int i = 0; i < 20; i++) cycle($urandom_range(1), 0, 4'($urandom), 0);
    cycle(1, 1, 8, 0);
    cycle(1, 1, 8, 0);
    idle(3, 8);
    do_reset();
    idle(15, 8);
    chk("post_reset_acks", ack_count, 0);
    for (int s = 0; s < 6; s++) begin
      int preq = 10 + 15 * s, pen = 60 + 8 * s, pinj = 5 * s, dmax = (s % 2) ? 15 : 3;
      for (int i = 0; i < 250; i++)
        cycle($urandom_range(99) < preq, $urandom_range(99) < pen,
              4'($urandom_range(dmax)), $urandom_range(99) < pinj);
      if (s == 2) do_reset();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
